// File: rtl/i2c_target_regbridge.sv
// I2C target that bridges an external master onto the internal register bus:
// device-ID check against a register, burst reads/writes with pointer auto-increment.
`timescale 1ns/1ps
module i2c_target_regbridge #(
  parameter  int ADDR_BYTES  = 2,
  parameter  int DATA_BYTES  = 2,
  parameter  int ID_REG_ADDR = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int ADDR_W      = 8 * ADDR_BYTES,
  localparam int DATA_W      = 8 * DATA_BYTES
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              SCL,
  input  logic              iSDA,
  output logic              oSDA,
  input  logic [DATA_W-1:0] RD_DATA,
  output logic [DATA_W-1:0] WR_DATA,
  output logic [ADDR_W-1:0] ADDR,
  output logic              RNW,
  output logic              req,
  output logic              goodCRC,
  output logic              busy
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_DEV_ADDR, ST_DEV_ACK, ST_REG_ADDR, ST_REG_ACK, ST_WR_DATA,
    ST_WR_ACK, ST_RD_FETCH, ST_RD_SHIFT, ST_RD_ACK, ST_WAIT_STOP
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   s_scl, s_sda, scl_rise, scl_fall, start_ev, stop_ev;

  state_e              state_q, ack_next_d;
  logic [6:0]          sh_q, dev_id_q;
  logic [7:0]          rx_byte, byte_cnt_q;
  logic [3:0]          bit_cnt_q;
  logic [ADDR_W-1:0]   ptr_q, ptr_d, addr_q;
  logic [DATA_W-1:0]   wbuf_q, wbuf_d, wr_data_q, rd_sh_q;
  logic                rw_q, fetch_ph_q, nack_q, busy_q, sda_o_q, req_q, rnw_q, goodcrc_q;

  // NOTE: synchronisers reset to 1 (released bus) so leaving reset can never fake a START/STOP.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], SCL};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], iSDA};
      scl_prev_q <= s_scl;
      sda_prev_q <= s_sda;
    end
  end

  assign s_scl    = scl_sync_q[SYNC_STAGES-1];
  assign s_sda    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = s_scl & ~scl_prev_q;
  assign scl_fall = ~s_scl & scl_prev_q;
  assign start_ev = s_scl & scl_prev_q & sda_prev_q & ~s_sda;
  assign stop_ev  = s_scl & scl_prev_q & ~sda_prev_q & s_sda;

  assign rx_byte = {sh_q, s_sda};
  assign ptr_d   = (ptr_q << 8) | ADDR_W'(rx_byte);
  assign wbuf_d  = (wbuf_q << 8) | DATA_W'(rx_byte);

  // Where an ACK slot leads once the master's 9th clock ends.
  always_comb begin
    ack_next_d = ST_WR_DATA;
    if (state_q == ST_DEV_ACK)
      ack_next_d = rw_q ? ST_RD_FETCH : ST_REG_ADDR;
    else if (state_q == ST_REG_ACK && byte_cnt_q != 8'(ADDR_BYTES))
      ack_next_d = ST_REG_ADDR;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      sh_q       <= '0;
      dev_id_q   <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      ptr_q      <= '0;
      wbuf_q     <= '0;
      rd_sh_q    <= '0;
      rw_q       <= 1'b0;
      fetch_ph_q <= 1'b0;
      nack_q     <= 1'b0;
      busy_q     <= 1'b0;
      sda_o_q    <= 1'b1;
      req_q      <= 1'b0;
      rnw_q      <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      goodcrc_q  <= 1'b0;
    end else begin
      // NOTE: strobes default low here; a later assignment in the same cycle takes precedence.
      req_q     <= 1'b0;
      goodcrc_q <= 1'b0;
      if (start_ev) begin
        state_q    <= ST_DEV_ADDR;
        busy_q     <= 1'b0;
        sda_o_q    <= 1'b1;
        bit_cnt_q  <= '0;
        byte_cnt_q <= '0;
        fetch_ph_q <= 1'b0;
      end else if (stop_ev) begin
        state_q    <= ST_IDLE;
        goodcrc_q  <= busy_q & ~nack_q;
        busy_q     <= 1'b0;
        nack_q     <= 1'b0;
        sda_o_q    <= 1'b1;
        bit_cnt_q  <= '0;
        byte_cnt_q <= '0;
        fetch_ph_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            req_q  <= 1'b1;
            rnw_q  <= 1'b1;
            addr_q <= ADDR_W'(ID_REG_ADDR);
            if (req_q) dev_id_q <= RD_DATA[6:0];
          end
          ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
            if (scl_rise) begin
              sh_q      <= rx_byte[6:0];
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q  <= '0;
                byte_cnt_q <= byte_cnt_q + 8'd1;
                if (state_q == ST_DEV_ADDR) begin
                  if (rx_byte[7:1] == dev_id_q) begin
                    rw_q    <= rx_byte[0];
                    state_q <= ST_DEV_ACK;
                  end else begin
                    nack_q  <= 1'b1;
                    state_q <= ST_WAIT_STOP;
                  end
                end else if (state_q == ST_REG_ADDR) begin
                  ptr_q   <= ptr_d;
                  state_q <= ST_REG_ACK;
                end else begin
                  state_q <= ST_WR_ACK;
                  if (byte_cnt_q == 8'(DATA_BYTES - 1)) begin
                    req_q      <= 1'b1;
                    rnw_q      <= 1'b0;
                    addr_q     <= ptr_q;
                    wr_data_q  <= wbuf_d;
                    ptr_q      <= ptr_q + 1'b1;
                    byte_cnt_q <= '0;
                  end else begin
                    wbuf_q <= wbuf_d;
                  end
                end
              end
            end
          end
          ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: begin
            if (scl_fall) begin
              if (sda_o_q) begin
                sda_o_q <= 1'b0;
                if (state_q == ST_DEV_ACK) busy_q <= 1'b1;
              end else begin
                sda_o_q   <= 1'b1;
                bit_cnt_q <= '0;
                state_q   <= ack_next_d;
                if (state_q == ST_DEV_ACK ||
                    (state_q == ST_REG_ACK && ack_next_d == ST_WR_DATA))
                  byte_cnt_q <= '0;
                if (ack_next_d == ST_RD_FETCH) begin
                  req_q      <= 1'b1;
                  rnw_q      <= 1'b1;
                  addr_q     <= ptr_q;
                  fetch_ph_q <= 1'b0;
                end
              end
            end
          end
          ST_RD_FETCH: begin
            if (!fetch_ph_q) begin
              fetch_ph_q <= 1'b1;
            end else begin
              fetch_ph_q <= 1'b0;
              sda_o_q    <= RD_DATA[DATA_W-1];
              rd_sh_q    <= {RD_DATA[DATA_W-2:0], 1'b0};
              ptr_q      <= ptr_q + 1'b1;
              bit_cnt_q  <= 4'd1;
              byte_cnt_q <= '0;
              state_q    <= ST_RD_SHIFT;
            end
          end
          ST_RD_SHIFT: begin
            if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_o_q    <= 1'b1;
                byte_cnt_q <= byte_cnt_q + 8'd1;
                state_q    <= ST_RD_ACK;
              end else begin
                sda_o_q   <= rd_sh_q[DATA_W-1];
                rd_sh_q   <= rd_sh_q << 1;
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise && s_sda) begin
              state_q <= ST_WAIT_STOP;
            end else if (scl_fall) begin
              if (byte_cnt_q == 8'(DATA_BYTES)) begin
                req_q      <= 1'b1;
                rnw_q      <= 1'b1;
                addr_q     <= ptr_q;
                fetch_ph_q <= 1'b0;
                state_q    <= ST_RD_FETCH;
              end else begin
                sda_o_q   <= rd_sh_q[DATA_W-1];
                rd_sh_q   <= rd_sh_q << 1;
                bit_cnt_q <= 4'd1;
                state_q   <= ST_RD_SHIFT;
              end
            end
          end
          ST_WAIT_STOP: sda_o_q <= 1'b1;
          default:      state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign oSDA    = sda_o_q;
  assign WR_DATA = wr_data_q;
  assign ADDR    = addr_q;
  assign RNW     = rnw_q;
  assign req     = req_q;
  assign goodCRC = goodcrc_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_target_regbridge.sv
// Directed bench for i2c_target_regbridge: bit-banged I2C master, open-drain SDA,
// register-file model and a bus monitor logging write/read strobes.
`timescale 1ns/1ps
module tb_i2c_target_regbridge;
  localparam int Q = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        osda, sda_bus;
  logic [15:0] rd_data = '0;
  logic [15:0] wr_data, addr;
  logic        rnw, req, good, busy;

  int pass_cnt = 0, chk_cnt = 0;
  int wr_cnt = 0, rd_cnt = 0, good_cnt = 0;
  logic [15:0] wr_addr_log [8];
  logic [15:0] wr_data_log [8];
  logic [15:0] rd_addr_log [8];

  assign sda_bus = m_sda & osda;

  i2c_target_regbridge #(.ADDR_BYTES(2), .DATA_BYTES(2), .ID_REG_ADDR(4), .SYNC_STAGES(2)) dut (
    .CLK(clk), .Reset(rst), .SCL(scl), .iSDA(sda_bus), .oSDA(osda), .RD_DATA(rd_data),
    .WR_DATA(wr_data), .ADDR(addr), .RNW(rnw), .req(req), .goodCRC(good), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] reg_val(input logic [15:0] a);
    case (a)
      16'h0004: return 16'h0042;
      16'h0020: return 16'hA5C3;
      16'h0021: return 16'h1234;
      default:  return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) if (req && rnw) rd_data <= reg_val(addr);

  always @(negedge clk) begin
    if (req && !rnw) begin
      if (wr_cnt < 8) begin
        wr_addr_log[wr_cnt] = addr;
        wr_data_log[wr_cnt] = wr_data;
      end
      wr_cnt++;
    end
    if (req && rnw && addr != 16'h0004) begin
      if (rd_cnt < 8) rd_addr_log[rd_cnt] = addr;
      rd_cnt++;
    end
    if (good) good_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic clock_bit(input logic b, output logic s);
    m_sda = b; #Q;
    scl = 1'b1; #Q;
    s = sda_bus; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(mack, s);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; #Q;
    scl = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #Q;
    scl = 1'b1; #Q;
    m_sda = 1'b1; #Q;
    #Q;
  endtask

  task automatic send_seq(input logic [7:0] seq [8], input int n, output int nacks);
    logic ack;
    nacks = 0;
    for (int i = 0; i < n; i++) begin
      write_byte(seq[i], ack);
      if (ack !== 1'b0) nacks++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++; if (osda !== 1'b1) $display("FAIL rst_osda: got %b want 1", osda); else pass_cnt++;
    chk_cnt++; if (req !== 1'b0) $display("FAIL rst_req: got %b want 0", req); else pass_cnt++;
    chk_cnt++; if (rnw !== 1'b0) $display("FAIL rst_rnw: got %b want 0", rnw); else pass_cnt++;
    chk_cnt++; if (addr !== 16'h0000) $display("FAIL rst_addr: got %h want 0000", addr); else pass_cnt++;
    chk_cnt++; if (wr_data !== 16'h0000) $display("FAIL rst_wrdata: got %h want 0000", wr_data); else pass_cnt++;
    chk_cnt++; if (good !== 1'b0) $display("FAIL rst_goodcrc: got %b want 0", good); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk_cnt++; if (req !== 1'b1) $display("FAIL idle_req: got %b want 1", req); else pass_cnt++;
    chk_cnt++; if (rnw !== 1'b1) $display("FAIL idle_rnw: got %b want 1", rnw); else pass_cnt++;
    chk_cnt++; if (addr !== 16'h0004) $display("FAIL idle_addr: got %h want 0004", addr); else pass_cnt++;
    chk_cnt++; if (dut.dev_id_q !== 7'h42) $display("FAIL dev_id: got %h want 42", dut.dev_id_q); else pass_cnt++;
    chk_cnt++; if (osda !== 1'b1) $display("FAIL idle_osda: got %b want 1", osda); else pass_cnt++;
  endtask

  task automatic test_write();
    logic [7:0] seq [8];
    logic ack;
    int b, g;
    seq = '{8'h84, 8'h00, 8'h10, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00};
    b = wr_cnt; g = good_cnt;
    i2c_start();
    for (int i = 0; i < 5; i++) begin
      write_byte(seq[i], ack);
      chk_cnt++; if (ack !== 1'b0) $display("FAIL write_ack[%0d]: got %b want 0", i, ack); else pass_cnt++;
    end
    chk_cnt++; if (busy !== 1'b1) $display("FAIL write_busy: got %b want 1", busy); else pass_cnt++;
    i2c_stop();
    repeat (5) @(negedge clk);
    chk_cnt++; if (wr_cnt - b != 1) $display("FAIL write_count: got %0d want 1", wr_cnt - b); else pass_cnt++;
    chk_cnt++; if (wr_addr_log[b] !== 16'h0010) $display("FAIL write_addr: got %h want 0010", wr_addr_log[b]); else pass_cnt++;
    chk_cnt++; if (wr_data_log[b] !== 16'hBEEF) $display("FAIL write_data: got %h want beef", wr_data_log[b]); else pass_cnt++;
    chk_cnt++; if (good_cnt - g != 1) $display("FAIL write_goodcrc: got %0d pulses want 1", good_cnt - g); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL write_busy_after_stop: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_burst();
    logic [7:0] seq [8];
    int b, g, nacks;
    seq = '{8'h84, 8'h00, 8'h10, 8'h11, 8'h11, 8'h22, 8'h22, 8'h00};
    b = wr_cnt; g = good_cnt;
    i2c_start();
    send_seq(seq, 7, nacks);
    i2c_stop();
    repeat (5) @(negedge clk);
    chk_cnt++; if (nacks != 0) $display("FAIL burst_acks: got %0d nacks want 0", nacks); else pass_cnt++;
    chk_cnt++; if (wr_cnt - b != 2) $display("FAIL burst_count: got %0d want 2", wr_cnt - b); else pass_cnt++;
    chk_cnt++; if (wr_addr_log[b] !== 16'h0010) $display("FAIL burst_addr0: got %h want 0010", wr_addr_log[b]); else pass_cnt++;
    chk_cnt++; if (wr_data_log[b] !== 16'h1111) $display("FAIL burst_data0: got %h want 1111", wr_data_log[b]); else pass_cnt++;
    chk_cnt++; if (wr_addr_log[b+1] !== 16'h0011) $display("FAIL burst_addr1: got %h want 0011", wr_addr_log[b+1]); else pass_cnt++;
    chk_cnt++; if (wr_data_log[b+1] !== 16'h2222) $display("FAIL burst_data1: got %h want 2222", wr_data_log[b+1]); else pass_cnt++;
    chk_cnt++; if (good_cnt - g != 1) $display("FAIL burst_goodcrc: got %0d pulses want 1", good_cnt - g); else pass_cnt++;
  endtask

  task automatic test_read();
    logic [7:0] seq [8];
    logic [7:0] exp_b [4];
    logic [7:0] d;
    logic ack;
    int bw, br, g, nacks;
    seq   = '{8'h84, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_b = '{8'hA5, 8'hC3, 8'h12, 8'h34};
    bw = wr_cnt; br = rd_cnt; g = good_cnt;
    i2c_start();
    send_seq(seq, 3, nacks);
    i2c_start();
    write_byte(8'h85, ack);
    chk_cnt++; if ((nacks != 0) || (ack !== 1'b0)) $display("FAIL read_hdr_acks: nacks %0d dev ack %b want 0/0", nacks, ack); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL read_busy: got %b want 1", busy); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      read_byte(i == 3, d);
      chk_cnt++; if (d !== exp_b[i]) $display("FAIL read_byte[%0d]: got %h want %h", i, d, exp_b[i]); else pass_cnt++;
    end
    i2c_stop();
    repeat (5) @(negedge clk);
    chk_cnt++; if (rd_cnt - br != 2) $display("FAIL read_count: got %0d want 2", rd_cnt - br); else pass_cnt++;
    chk_cnt++; if (rd_addr_log[br] !== 16'h0020) $display("FAIL read_addr0: got %h want 0020", rd_addr_log[br]); else pass_cnt++;
    chk_cnt++; if (rd_addr_log[br+1] !== 16'h0021) $display("FAIL read_addr1: got %h want 0021", rd_addr_log[br+1]); else pass_cnt++;
    chk_cnt++; if (wr_cnt != bw) $display("FAIL read_no_write: got %0d writes want 0", wr_cnt - bw); else pass_cnt++;
    chk_cnt++; if (good_cnt - g != 1) $display("FAIL read_goodcrc: got %0d pulses want 1", good_cnt - g); else pass_cnt++;
  endtask

  task automatic test_wrong_id();
    logic ack;
    int bw, br, g;
    bw = wr_cnt; br = rd_cnt; g = good_cnt;
    i2c_start();
    write_byte(8'h90, ack);
    chk_cnt++; if (ack !== 1'b1) $display("FAIL wrongid_nack: got %b want 1", ack); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL wrongid_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (req !== 1'b0) $display("FAIL wrongid_req: got %b want 0", req); else pass_cnt++;
    i2c_stop();
    repeat (5) @(negedge clk);
    chk_cnt++; if ((wr_cnt != bw) || (rd_cnt != br)) $display("FAIL wrongid_access: got %0d/%0d want 0/0", wr_cnt - bw, rd_cnt - br); else pass_cnt++;
    chk_cnt++; if (good_cnt != g) $display("FAIL wrongid_goodcrc: got %0d pulses want 0", good_cnt - g); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] seq [8];
    logic s;
    int b, nacks;
    seq = '{8'h84, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    b = wr_cnt;
    i2c_start();
    send_seq(seq, 3, nacks);
    for (int i = 7; i >= 0; i--) clock_bit(i[0], s);
    m_sda = 1'b1; #Q;
    scl = 1'b1; #Q;
    chk_cnt++; if (osda !== 1'b0) $display("FAIL mid_ack_low: got %b want 0", osda); else pass_cnt++;
    rst = 1'b1;
    #1;
    chk_cnt++; if (osda !== 1'b1) $display("FAIL reset_release_osda: got %b want 1", osda); else pass_cnt++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk_cnt++; if (wr_cnt != b) $display("FAIL reset_no_write: got %0d writes want 0", wr_cnt - b); else pass_cnt++;
    seq = '{8'h84, 8'h00, 8'h30, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00};
    i2c_start();
    send_seq(seq, 5, nacks);
    i2c_stop();
    repeat (5) @(negedge clk);
    chk_cnt++; if (nacks != 0) $display("FAIL post_reset_acks: got %0d nacks want 0", nacks); else pass_cnt++;
    chk_cnt++; if (wr_cnt - b != 1) $display("FAIL post_reset_count: got %0d want 1", wr_cnt - b); else pass_cnt++;
    chk_cnt++; if (wr_addr_log[b] !== 16'h0030) $display("FAIL post_reset_addr: got %h want 0030", wr_addr_log[b]); else pass_cnt++;
    chk_cnt++; if (wr_data_log[b] !== 16'h1234) $display("FAIL post_reset_data: got %h want 1234", wr_data_log[b]); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_burst();
    test_read();
    test_wrong_id();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
